ram_march_bist: RTL

- Built-in self-test initiator that drives a single-port RAM's wr/addr/din port and checks its asynchronous-read dout.
- The RAM has 2^N words of M bits, a synchronous write, and dout = mem[addr] combinationally.
- Runs a March C- style sequence on a start pulse and reports pass/fail, the first failing location and the mismatch count.
- Sits between the RAM and the test/control logic; it is the initiator end of the RAM port.

---
 rtl/ram_march_bist.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- built-in self-test initiator for a single-port RAM
// that has a synchronous write and an asynchronous (combinational) read port.
//
// Handshake: there is no valid/ready pair. A one-cycle (or longer) start is
// accepted only in IDLE or DONE. busy is high for exactly 6*2^N cycles. done
// then stays high with stable results until the next accepted start or reset.
//
// Sequence, one cycle per address:
//   E0 up   : write D0
//   E1 up   : read D0, write D1
//   E2 up   : read D1, write D0
//   E3 down : read D0, write D1
//   E4 down : read D1, write D0
//   E5 up   : read D0
// The RAM port is decoded only from the element and address registers. This
// keeps mem_dout and start out of the mem_wr, mem_addr and mem_din paths.
// Because the port is decoded from async-reset registers, it drops to zero as
// soon as rst_n falls.
module ram_march_bist #(
  parameter int N = 6,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         mem_wr,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_din,
  input  logic [M-1:0] mem_dout,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N+2:0] err_count,
  output logic [N-1:0] fail_addr,
  output logic [M-1:0] fail_exp,
  output logic [M-1:0] fail_data,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  localparam logic [N-1:0] ADDR_MAX = {N{1'b1}};
  localparam logic [M-1:0] D0       = {M{1'b0}};
  localparam logic [M-1:0] D1       = {M{1'b1}};

  logic [1:0]   r_state;
  logic [2:0]   r_elem;
  logic [N-1:0] r_addr;
  logic         r_pass;
  logic [N+2:0] r_err_count;
  logic [N-1:0] r_fail_addr;
  logic [M-1:0] r_fail_exp;
  logic [M-1:0] r_fail_data;

  logic         w_run;
  logic         w_down;
  logic         w_last;
  logic         w_rd;
  logic         w_wr;
  logic [M-1:0] w_exp;
  logic [M-1:0] w_wdata;
  logic         w_mismatch;
  logic         w_first;
  logic [N+2:0] w_err_next;
  logic [N-1:0] w_next_start;
  logic         w_accept;

  // Element decode: address direction, read/write activity and the data patterns
  always_comb begin
    w_run        = (r_state == S_RUN);
    w_down       = (r_elem == E3) || (r_elem == E4);
    w_last       = w_down ? (r_addr == '0) : (r_addr == ADDR_MAX);
    w_rd         = w_run && (r_elem != E0);
    w_wr         = w_run && (r_elem != E5);
    w_exp        = ((r_elem == E2) || (r_elem == E4)) ? D1 : D0;
    w_wdata      = ((r_elem == E1) || (r_elem == E3)) ? D1 : D0;
    w_mismatch   = w_rd && (mem_dout != w_exp);
    w_first      = w_mismatch && (r_err_count == '0);
    w_err_next   = r_err_count + {{(N+2){1'b0}}, w_mismatch};
    // The next element counts down (E3, E4) when the current one is E2 or E3.
    w_next_start = ((r_elem == E2) || (r_elem == E3)) ? ADDR_MAX : '0;
    w_accept     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Sequencer: state, element and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_elem  <= E0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_elem  <= E0;
            r_addr  <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            if (r_elem == E5) begin
              r_state <= S_DONE;
              r_elem  <= E0;
              r_addr  <= '0;
            end else begin
              r_elem <= r_elem + 3'd1;
              r_addr <= w_next_start;
            end
          end else if (w_down) begin
            r_addr <= r_addr - 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_elem  <= E0;
          r_addr  <= '0;
        end
      endcase
    end
  end

  // Result registers: mismatch count, first-failure capture and final verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_data <= '0;
    end else if (w_accept) begin
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_data <= '0;
    end else if (w_run) begin
      r_err_count <= w_err_next;
      if (w_first) begin
        r_fail_addr <= r_addr;
        r_fail_exp  <= w_exp;
        r_fail_data <= mem_dout;
      end
      // The mismatch from the final E5 cycle counts toward the verdict.
      if (w_last && (r_elem == E5)) begin
        r_pass <= (w_err_next == '0);
      end
    end
  end

  // RAM port: write data is forced to zero whenever no write is issued
  always_comb begin
    mem_wr   = w_wr;
    mem_addr = r_addr;
    mem_din  = w_wr ? w_wdata : '0;
  end

  // Status outputs
  always_comb begin
    busy      = w_run;
    done      = (r_state == S_DONE);
    pass      = r_pass;
    err_count = r_err_count;
    fail_addr = r_fail_addr;
    fail_exp  = r_fail_exp;
    fail_data = r_fail_data;
    dbg_state = r_state;
  end

endmodule
